updown_count_ctrl: RTL and testbench
====================================

Name: updown_count_ctrl

Overview:
- Sequencing controller for the two-digit 00–99 up/down counter shown on the 4-digit seven-segment display.
- Takes debounced, one-pulsed enable and direction button events and owns the run/pause/limit state machine.
- Generates the count-step timing internally and holds the count as two BCD digits.
- Outputs the digit values, the direction glyph code and the max/min LEDs to the display path.

Parameters:
- TICK_DIV, 33554432: clk cycles per count step; legal range ≥2.
- MAX_VAL, 99: upper count limit; fixed two-digit BCD, legal range 1–99.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- en_pulse  input  1  single-cycle enable button event, already debounced/one-pulsed in clk domain
- dir_pulse  input  1  single-cycle direction button event, same conditioning as en_pulse
- tens  output  4  BCD tens digit of count
- ones  output  4  BCD ones digit of count
- dir_code  output  4  display glyph code: 11 = up, 10 = down
- running  output  1  high while in RUN
- state  output  2  encoded FSM state: PAUSE=0, RUN=1, DONE=2
- max  output  1  count==MAX_VAL and direction up
- min  output  1  count==0 and direction down

Behaviour:
- Clock and reset: one clock domain, all state in clk. Reset is synchronous and active-high; it wins over every other input.
- Reset values: tens=0, ones=0, dir=up (dir_code=11), state=PAUSE, prescaler=0, running=0, max=0, min=0.
- Registered outputs: tens, ones, dir_code, state and running are registered.
- Combinational outputs: max and min are decoded from registered count and dir, with no extra latency.
- Prescaler:
  - Counts 0..TICK_DIV-1 only while in RUN and wraps to 0.
  - Cleared on every entry to RUN.
  - step = (state==RUN) && (prescaler==TICK_DIV-1).
  - First step lands exactly TICK_DIV cycles after the RUN-entry edge.
- Count update: happens on the edge ending the step cycle.
  - Up: BCD increment; ones 9→0 with tens+1.
  - Down: BCD decrement; ones 0→9 with tens-1.
  - Never wraps: count saturates at MAX_VAL and at 0.
- PAUSE state:
  - Count frozen, prescaler held at 0.
  - en_pulse → RUN.
  - dir_pulse toggles dir; stays in PAUSE.
- RUN state:
  - If a step lands the count on the limit in the current direction (MAX_VAL up, 0 down), go to DONE on that same edge.
  - en_pulse → PAUSE; prescaler cleared.
  - dir_pulse toggles dir; prescaler not cleared; stays in RUN.
- RUN entered while already at the limit (e.g. en_pulse at 00 going down):
  - Go to DONE on the next step edge.
  - Count unchanged.
- DONE state:
  - Count frozen, running=0.
  - dir_pulse toggles dir → RUN with the new direction; prescaler cleared.
  - en_pulse → PAUSE.
- Simultaneous events:
  - en_pulse on a step cycle: pause wins; step suppressed; count unchanged.
  - dir_pulse on a step cycle: the step uses the old dir; the new dir applies from the next step.
  - en_pulse and dir_pulse together: both take effect (dir toggles and the state transition happens).
    - DONE + both → PAUSE with toggled dir.
- max/min outputs:
  - Follow count and dir in every state, including PAUSE.
  - Flipping dir at a limit clears the corresponding LED in the same cycle dir updates.
- Reset mid-operation: returns everything to reset values on the next edge, regardless of state or prescaler phase.

Decomposition:
- Shared package holds:
  - state encoding constants: ST_PAUSE, ST_RUN, ST_DONE
  - glyph constants: GLYPH_UP=11, GLYPH_DOWN=10
  - BCD digit width constant 4
- Sub-module bcd2_step is the natural split:
  - Combinational two-digit BCD increment/decrement.
  - Saturates at MAX_VAL/0.
  - Outputs at_limit.
  - Reused by any later timer/countdown block.

Test Plan:
1. Reset: rst=1 for 2 cycles, then release → tens=0, ones=0, dir_code=11, state=0, running=0, max=0, min=0.
2. Up count with carry (TICK_DIV=4): en_pulse at cycle 0 → count 01 at cycle 4, 02 at cycle 8; preload path 09 steps to 10; running=1.
3. Up saturation: run to 99 → state=2 (DONE), max=1, running=0; 20 further cycles leave 99.
4. Reverse from DONE: at 99, dir_pulse → state=1, dir_code=10, max=0; count 98 exactly 4 cycles later; 10 steps to 09 (borrow).
5. Down limit then pause: reach 00 → DONE, min=1; en_pulse → state=0, min stays 1, count 00.
6. Collisions:
   - en_pulse on a step cycle at 05 → PAUSE, count stays 05.
   - dir_pulse on a step cycle at 05 going up → 06, then next step 05.
   - rst mid-RUN at 42 → 00, up, PAUSE, prescaler 0.

Source files
------------

// File: rtl/updown_count_ctrl_pkg.sv
// Shared definitions for the two-digit up/down counter controller:
// FSM state encoding, display glyph codes and the BCD digit width.
package updown_count_ctrl_pkg;

    localparam int DIGIT_W = 4;

    typedef enum logic [1:0] {
        ST_PAUSE = 2'd0,
        ST_RUN   = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic [DIGIT_W-1:0] GLYPH_UP   = 4'd11;
    localparam logic [DIGIT_W-1:0] GLYPH_DOWN = 4'd10;

endpackage

// File: rtl/updown_count_ctrl_bcd2_step.sv
// Combinational two-digit BCD increment/decrement that saturates at MAX_VAL
// going up and at 00 going down; also flags the limit before and after the step.
module bcd2_step
    import updown_count_ctrl_pkg::*;
#(
    parameter int MAX_VAL = 99
) (
    input  logic [DIGIT_W-1:0] tens,
    input  logic [DIGIT_W-1:0] ones,
    input  logic               up,
    output logic [DIGIT_W-1:0] next_tens,
    output logic [DIGIT_W-1:0] next_ones,
    output logic               at_limit,
    output logic               next_at_limit
);

    localparam logic [DIGIT_W-1:0] MAX_T = DIGIT_W'(MAX_VAL / 10);
    localparam logic [DIGIT_W-1:0] MAX_O = DIGIT_W'(MAX_VAL % 10);

    always_comb begin
        next_tens = tens;
        next_ones = ones;
        at_limit  = up ? (tens == MAX_T && ones == MAX_O) : (tens == '0 && ones == '0);
        if (!at_limit) begin
            if (up) begin
                if (ones == 4'd9) begin
                    next_ones = '0;
                    next_tens = tens + 4'd1;
                end else begin
                    next_ones = ones + 4'd1;
                end
            end else begin
                if (ones == '0) begin
                    next_ones = 4'd9;
                    next_tens = tens - 4'd1;
                end else begin
                    next_ones = ones - 4'd1;
                end
            end
        end
        next_at_limit = up ? (next_tens == MAX_T && next_ones == MAX_O)
                           : (next_tens == '0 && next_ones == '0);
    end

endmodule

// File: rtl/updown_count_ctrl.sv
// Run/pause/limit sequencing for the 00-99 up/down counter: prescaled step
// timing, BCD count register, direction glyph and max/min limit LEDs.
module updown_count_ctrl
    import updown_count_ctrl_pkg::*;
#(
    parameter int TICK_DIV = 33554432,
    parameter int MAX_VAL  = 99
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en_pulse,
    input  logic               dir_pulse,
    output logic [DIGIT_W-1:0] tens,
    output logic [DIGIT_W-1:0] ones,
    output logic [DIGIT_W-1:0] dir_code,
    output logic               running,
    output logic [1:0]         state,
    output logic               max,
    output logic               min
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    state_t               state_q;
    logic [PW-1:0]        presc;
    logic [DIGIT_W-1:0]   next_tens;
    logic [DIGIT_W-1:0]   next_ones;
    logic                 at_limit;
    logic                 next_at_limit;
    logic                 dir_up;
    logic                 step;

    assign dir_up = (dir_code == GLYPH_UP);
    assign step   = (state_q == ST_RUN) && (presc == PW'(TICK_DIV - 1));
    assign state  = state_q;
    assign max    = at_limit && dir_up;
    assign min    = at_limit && !dir_up;

    bcd2_step #(
        .MAX_VAL(MAX_VAL)
    ) u_step (
        .tens         (tens),
        .ones         (ones),
        .up           (dir_up),
        .next_tens    (next_tens),
        .next_ones    (next_ones),
        .at_limit     (at_limit),
        .next_at_limit(next_at_limit)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_PAUSE;
            presc    <= '0;
            tens     <= '0;
            ones     <= '0;
            dir_code <= GLYPH_UP;
            running  <= 1'b0;
        end else begin
            if (dir_pulse) begin
                dir_code <= dir_up ? GLYPH_DOWN : GLYPH_UP;
            end
            case (state_q)
                ST_PAUSE: begin
                    presc <= '0;
                    if (en_pulse) begin
                        state_q <= ST_RUN;
                        running <= 1'b1;
                    end
                end
                ST_RUN: begin
                    // A pause request beats a coincident step; the step itself uses the old direction
                    if (en_pulse) begin
                        state_q <= ST_PAUSE;
                        running <= 1'b0;
                        presc   <= '0;
                    end else if (step) begin
                        presc <= '0;
                        if (at_limit) begin
                            state_q <= ST_DONE;
                            running <= 1'b0;
                        end else begin
                            tens <= next_tens;
                            ones <= next_ones;
                            if (next_at_limit) begin
                                state_q <= ST_DONE;
                                running <= 1'b0;
                            end
                        end
                    end else begin
                        presc <= presc + PW'(1);
                    end
                end
                ST_DONE: begin
                    presc <= '0;
                    if (en_pulse) begin
                        state_q <= ST_PAUSE;
                        running <= 1'b0;
                    end else if (dir_pulse) begin
                        state_q <= ST_RUN;
                        running <= 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_PAUSE;
                    running <= 1'b0;
                    presc   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_updown_count_ctrl.sv
// Directed self-checking bench for updown_count_ctrl with TICK_DIV=4, MAX_VAL=99.
module tb_updown_count_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       en_pulse;
    logic       dir_pulse;
    logic [3:0] tens;
    logic [3:0] ones;
    logic [3:0] dir_code;
    logic       running;
    logic [1:0] state;
    logic       max;
    logic       min;

    int errors = 0;
    int checks = 0;

    updown_count_ctrl #(
        .TICK_DIV(4),
        .MAX_VAL (99)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en_pulse (en_pulse),
        .dir_pulse(dir_pulse),
        .tens     (tens),
        .ones     (ones),
        .dir_code (dir_code),
        .running  (running),
        .state    (state),
        .max      (max),
        .min      (min)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drive the button events for exactly one clock edge
    task automatic applyStimulus(input logic en, input logic dir);
        en_pulse  = en;
        dir_pulse = dir;
        tick(1);
        en_pulse  = 1'b0;
        dir_pulse = 1'b0;
    endtask

    task automatic checkField(input string tag, input int observed, input int expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic checkOutput(input string tag, input int exp_count, input int exp_dir,
                               input int exp_state, input int exp_run,
                               input int exp_max, input int exp_min);
        checkField({tag, ".tens"},     int'(tens),     exp_count / 10);
        checkField({tag, ".ones"},     int'(ones),     exp_count % 10);
        checkField({tag, ".dir_code"}, int'(dir_code), exp_dir);
        checkField({tag, ".state"},    int'(state),    exp_state);
        checkField({tag, ".running"},  int'(running),  exp_run);
        checkField({tag, ".max"},      int'(max),      exp_max);
        checkField({tag, ".min"},      int'(min),      exp_min);
    endtask

    task automatic checkCount(input string tag, input int exp_count);
        checkField({tag, ".tens"}, int'(tens), exp_count / 10);
        checkField({tag, ".ones"}, int'(ones), exp_count % 10);
    endtask

    initial begin
        rst       = 1'b1;
        en_pulse  = 1'b0;
        dir_pulse = 1'b0;
        tick(2);
        rst = 1'b0;
        checkOutput("reset", 0, 11, 0, 0, 0, 0);

        // Up counting with BCD carry, first step exactly 4 cycles after RUN entry
        applyStimulus(1'b1, 1'b0);
        checkOutput("run_entry", 0, 11, 1, 1, 0, 0);
        tick(3);
        checkCount("before_first_step", 0);
        tick(1);
        checkCount("first_step", 1);
        tick(4);
        checkCount("second_step", 2);
        for (int v = 3; v <= 98; v++) begin
            tick(4);
            checkCount($sformatf("up_%0d", v), v);
        end
        tick(4);
        checkOutput("up_saturate", 99, 11, 2, 0, 1, 0);
        tick(20);
        checkOutput("done_hold", 99, 11, 2, 0, 1, 0);

        // Reverse out of DONE, then count down with borrow to 00
        applyStimulus(1'b0, 1'b1);
        checkOutput("reverse", 99, 10, 1, 1, 0, 0);
        tick(4);
        checkCount("down_first", 98);
        for (int v = 97; v >= 1; v--) begin
            tick(4);
            checkCount($sformatf("down_%0d", v), v);
        end
        tick(4);
        checkOutput("down_limit", 0, 10, 2, 0, 0, 1);
        applyStimulus(1'b1, 1'b0);
        checkOutput("done_pause", 0, 10, 0, 0, 0, 1);
        applyStimulus(1'b0, 1'b1);
        checkOutput("pause_dir", 0, 11, 0, 0, 0, 0);

        // en_pulse on a step cycle at 05: pause wins, count stays
        applyStimulus(1'b1, 1'b0);
        tick(20);
        checkCount("at_05", 5);
        tick(3);
        applyStimulus(1'b1, 1'b0);
        checkOutput("en_on_step", 5, 11, 0, 0, 0, 0);

        // dir_pulse on a step cycle: old direction used for that step
        applyStimulus(1'b1, 1'b0);
        tick(3);
        applyStimulus(1'b0, 1'b1);
        checkOutput("dir_on_step", 6, 10, 1, 1, 0, 0);
        tick(4);
        checkCount("dir_next_step", 5);

        // dir_pulse off a step cycle keeps prescaler phase
        applyStimulus(1'b0, 1'b1);
        checkOutput("dir_mid", 5, 11, 1, 1, 0, 0);
        tick(2);
        checkCount("dir_mid_hold", 5);
        tick(1);
        checkCount("dir_mid_step", 6);
        tick(4 * 36);
        checkOutput("at_42", 42, 11, 1, 1, 0, 0);

        // Reset in the middle of a prescaler period
        tick(2);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        checkOutput("reset_mid_run", 0, 11, 0, 0, 0, 0);
        applyStimulus(1'b1, 1'b0);
        tick(3);
        checkCount("post_reset_hold", 0);
        tick(1);
        checkCount("post_reset_step", 1);

        // RUN entered already at the down limit: DONE on the next step edge
        tick(1);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        applyStimulus(1'b0, 1'b1);
        checkOutput("pause_down_at_0", 0, 10, 0, 0, 0, 1);
        applyStimulus(1'b1, 1'b0);
        checkOutput("run_at_limit", 0, 10, 1, 1, 0, 1);
        tick(3);
        checkField("run_at_limit_wait.state", int'(state), 1);
        tick(1);
        checkOutput("run_at_limit_done", 0, 10, 2, 0, 0, 1);

        // Both events together in DONE: pause with toggled direction
        applyStimulus(1'b1, 1'b1);
        checkOutput("done_both", 0, 11, 0, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
